tcdm_block_initiator: RTL and testbench

//  TCDM bus initiator (master side) that runs a block fill or a block check on any 1-cycle TCDM slave.

---
 rtl/tcdm_block_initiator_if.sv | 26 ++
 rtl/tcdm_block_initiator.sv | 186 ++++++++++++++++++
 tb/tb_tcdm_block_initiator.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tcdm_block_initiator_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tcdm_block_initiator_if : single-cycle TCDM request/response bus
// Rev 1.0
// ----------------------------------------------------------------------------
interface tcdm_block_initiator_if;
  logic        req;
  logic [31:0] add;
  logic        wen;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        gnt;
  logic        r_valid;
  logic [31:0] r_rdata;

  modport master (
    output req, add, wen, wdata, be,
    input  gnt, r_valid, r_rdata
  );

  modport slave (
    input  req, add, wen, wdata, be,
    output gnt, r_valid, r_rdata
  );
endinterface
`default_nettype wire

// File: rtl/tcdm_block_initiator.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tcdm_block_initiator : TCDM master running a pattern block fill or read-check
// Rev 1.0
// ----------------------------------------------------------------------------
module tcdm_block_initiator #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int LEN_WIDTH       = 16
) (
  input  wire                  clk_i,
  input  wire                  rst_ni,
  input  wire                  cmd_valid_i,
  output logic                 cmd_ready_o,
  input  wire                  cmd_op_i,
  input  wire [31:0]           cmd_addr_i,
  input  wire [LEN_WIDTH-1:0]  cmd_len_i,
  input  wire [31:0]           cmd_pattern_i,
  tcdm_block_initiator_if.master tcdm,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [15:0]          err_cnt_o,
  output logic [31:0]          err_addr_o
);

  localparam int                 c_OUT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [c_OUT_W-1:0] c_MAX_OUT = c_OUT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e               r_state;
  state_e               w_state_nxt;

  logic                 r_op;
  logic [31:0]          r_addr;
  logic [LEN_WIDTH-1:0] r_len;
  logic [31:0]          r_pattern;
  logic [LEN_WIDTH-1:0] r_issue_cnt;
  logic [LEN_WIDTH-1:0] r_rsp_cnt;
  logic [c_OUT_W-1:0]   r_outst;

  logic                 r_req;
  logic [31:0]          r_add;
  logic                 r_wen;
  logic [31:0]          r_wdata;
  logic [15:0]          r_err_cnt;
  logic [31:0]          r_err_addr;

  logic                 w_accept;
  logic                 w_fire;
  logic                 w_rsp;
  logic                 w_mismatch;
  logic                 w_req_nxt;
  logic [LEN_WIDTH-1:0] w_issue_nxt;
  logic [c_OUT_W-1:0]   w_outst_nxt;
  logic [31:0]          w_exp_data;
  logic [31:0]          w_rsp_addr;

  assign tcdm.req   = r_req;
  assign tcdm.add   = r_add;
  assign tcdm.wen   = r_wen;
  assign tcdm.wdata = r_wdata;
  assign tcdm.be    = 4'hF;

  assign err_cnt_o  = r_err_cnt;
  assign err_addr_o = r_err_addr;

  assign w_accept = cmd_valid_i & cmd_ready_o;
  assign w_fire   = r_req & tcdm.gnt;
  // Responses with nothing outstanding are strays and must not move any state.
  assign w_rsp    = tcdm.r_valid & (r_state == S_RUN) & (r_outst != '0);

  assign w_exp_data = r_pattern + 32'(r_rsp_cnt);
  assign w_rsp_addr = r_addr + (32'(r_rsp_cnt) << 2);
  assign w_mismatch = w_rsp & ~r_op & (tcdm.r_rdata != w_exp_data);

  always_comb begin
    w_issue_nxt = r_issue_cnt;
    if (w_fire) begin
      w_issue_nxt = r_issue_cnt + LEN_WIDTH'(1);
    end

    w_outst_nxt = r_outst;
    unique case ({w_fire, w_rsp})
      2'b10:   w_outst_nxt = r_outst + c_OUT_W'(1);
      2'b01:   w_outst_nxt = r_outst - c_OUT_W'(1);
      default: w_outst_nxt = r_outst;
    endcase

    // An ungranted request is held; otherwise issue while words remain and
    // the outstanding window (including this cycle's traffic) has room.
    w_req_nxt = (r_req & ~tcdm.gnt) |
                ((w_issue_nxt < r_len) & (w_outst_nxt < c_MAX_OUT));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    cmd_ready_o = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          w_state_nxt = (cmd_len_i == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        busy_o = 1'b1;
        if ((w_issue_nxt == r_len) && (w_outst_nxt == '0)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done_o      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_op        <= 1'b0;
      r_addr      <= '0;
      r_len       <= '0;
      r_pattern   <= '0;
      r_issue_cnt <= '0;
      r_rsp_cnt   <= '0;
      r_outst     <= '0;
      r_req       <= 1'b0;
      r_add       <= '0;
      r_wen       <= 1'b1;
      r_wdata     <= '0;
      r_err_cnt   <= '0;
      r_err_addr  <= '0;
    end else if (w_accept) begin
      r_op        <= cmd_op_i;
      r_addr      <= cmd_addr_i & 32'hFFFF_FFFC;
      r_len       <= cmd_len_i;
      r_pattern   <= cmd_pattern_i;
      r_issue_cnt <= '0;
      r_rsp_cnt   <= '0;
      r_outst     <= '0;
      r_req       <= (cmd_len_i != '0);
      r_add       <= cmd_addr_i & 32'hFFFF_FFFC;
      r_wen       <= ~cmd_op_i;
      r_wdata     <= cmd_pattern_i;
      r_err_cnt   <= '0;
      r_err_addr  <= '0;
    end else if (r_state == S_RUN) begin
      r_issue_cnt <= w_issue_nxt;
      r_outst     <= w_outst_nxt;
      r_req       <= w_req_nxt;
      // Address/data run ahead on every grant so the next word is ready.
      if (w_fire) begin
        r_add   <= r_add + 32'd4;
        r_wdata <= r_wdata + 32'd1;
      end
      if (w_rsp) begin
        r_rsp_cnt <= r_rsp_cnt + LEN_WIDTH'(1);
      end
      if (w_mismatch) begin
        if (r_err_cnt != 16'hFFFF) begin
          r_err_cnt <= r_err_cnt + 16'd1;
        end
        if (r_err_cnt == '0) begin
          r_err_addr <= w_rsp_addr;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tcdm_block_initiator.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_tcdm_block_initiator : directed vector bench with a TCDM memory slave model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_tcdm_block_initiator;

  localparam int MAX_OUT = 2;
  localparam int LW      = 16;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          cmd_valid_i = 1'b0;
  logic          cmd_ready_o;
  logic          cmd_op_i = 1'b0;
  logic [31:0]   cmd_addr_i = '0;
  logic [LW-1:0] cmd_len_i = '0;
  logic [31:0]   cmd_pattern_i = '0;
  logic          busy_o;
  logic          done_o;
  logic [15:0]   err_cnt_o;
  logic [31:0]   err_addr_o;

  always #5 clk_i = ~clk_i;

  tcdm_block_initiator_if bus ();

  tcdm_block_initiator #(
    .MAX_OUTSTANDING (MAX_OUT),
    .LEN_WIDTH       (LW)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .cmd_valid_i   (cmd_valid_i),
    .cmd_ready_o   (cmd_ready_o),
    .cmd_op_i      (cmd_op_i),
    .cmd_addr_i    (cmd_addr_i),
    .cmd_len_i     (cmd_len_i),
    .cmd_pattern_i (cmd_pattern_i),
    .tcdm          (bus),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_cnt_o     (err_cnt_o),
    .err_addr_o    (err_addr_o)
  );

  // Slave model: memory plus in-order response queue, decisions at negedge.
  bit          slv_en = 1'b0;
  bit          stall_mode = 1'b0;
  logic        gnt_en = 1'b0;
  logic        s_rvalid = 1'b0;
  logic [31:0] s_rdata = '0;
  logic        man_gnt = 1'b0;
  logic        man_rvalid = 1'b0;

  assign bus.gnt     = bus.req & (slv_en ? gnt_en : man_gnt);
  assign bus.r_valid = slv_en ? s_rvalid : man_rvalid;
  assign bus.r_rdata = s_rdata;

  typedef struct {
    int          due;
    logic [29:0] wa;
  } rsp_t;

  rsp_t        q[$];
  logic [31:0] mem [logic [29:0]];
  int          cyc = 0;
  int          tot_fires = 0, tot_rsp = 0, tot_req_cyc = 0;
  int          tot_fire_bad = 0, tot_stab_bad = 0, tot_ovf = 0;
  int          rise_cyc = -1, last_req_cyc = -1, tb_outst = 0, last_due = 0;
  int          fire_base = 0;
  logic [31:0] exp_base = '0, exp_pat = '0;
  bit          exp_op = 1'b0;
  bit          corrupt_en = 1'b0;
  logic [29:0] corrupt_wa = '0;
  bit          prev_req = 1'b0, prev_pend = 1'b0;
  logic [31:0] prev_add = '0, prev_wdata = '0;
  logic        prev_wen = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    int          k;
    int          due;
    logic [31:0] ea, ed;
    rsp_t        r;
    if (!rst_ni || !slv_en) begin
      q.delete();
      tb_outst  = 0;
      last_due  = 0;
      prev_pend = 1'b0;
      gnt_en    = 1'b0;
      s_rvalid  = 1'b0;
    end else begin
      if (bus.req) begin
        tot_req_cyc++;
        if (!prev_req) rise_cyc = cyc;
        last_req_cyc = cyc;
      end
      if (prev_pend && (!bus.req || bus.add !== prev_add ||
                        bus.wdata !== prev_wdata || bus.wen !== prev_wen)) begin
        tot_stab_bad++;
        $display("note: cycle %0d request changed while ungranted", cyc);
      end
      gnt_en = stall_mode ? ($urandom_range(0, 99) < 55) : 1'b1;
      if (bus.req && gnt_en) begin
        k  = tot_fires - fire_base;
        ea = exp_base + 32'(k) * 32'd4;
        ed = exp_pat + 32'(k);
        if (bus.add !== ea || bus.wen !== !exp_op || bus.be !== 4'hF ||
            (exp_op && bus.wdata !== ed)) begin
          tot_fire_bad++;
          $display("note: word %0d add=%h wen=%b wdata=%h, want add=%h wen=%b wdata=%h",
                   k, bus.add, bus.wen, bus.wdata, ea, !exp_op, ed);
        end
        if (tb_outst >= MAX_OUT) tot_ovf++;
        if (!bus.wen) mem[bus.add[31:2]] = bus.wdata;
        due = cyc + 1 + (stall_mode ? int'($urandom_range(0, 3)) : 0);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        r.due = due;
        r.wa  = bus.add[31:2];
        q.push_back(r);
        tot_fires++;
        tb_outst++;
      end
      prev_pend  = bus.req && !gnt_en;
      prev_add   = bus.add;
      prev_wdata = bus.wdata;
      prev_wen   = bus.wen;
      s_rvalid   = 1'b0;
      s_rdata    = 32'hBAD0_0000 | 32'(cyc);
      if (q.size() > 0 && q[0].due == cyc) begin
        s_rvalid = 1'b1;
        s_rdata  = mem.exists(q[0].wa) ? mem[q[0].wa] : 32'hDEAD_BEEF;
        if (corrupt_en && q[0].wa == corrupt_wa) s_rdata = s_rdata ^ 32'h0000_0100;
        void'(q.pop_front());
        tot_rsp++;
        tb_outst--;
      end
    end
    prev_req = bus.req;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          op;
    logic [31:0] addr;
    int          len;
    logic [31:0] pat;
    bit          stall;
    int          corrupt;
    logic [15:0] exp_err;
    logic [31:0] exp_eaddr;
    int          exp_lat;
  } vec_t;

  task automatic run_vec(input string tag, input vec_t v);
    int          t0, dcyc, f0, r0, q0, s0, o0, b0, bad;
    logic [31:0] base;
    logic [29:0] wa;
    base       = v.addr & 32'hFFFF_FFFC;
    fire_base  = tot_fires;
    exp_base   = base;
    exp_pat    = v.pat;
    exp_op     = v.op;
    stall_mode = v.stall;
    slv_en     = 1'b1;
    corrupt_en = (v.corrupt >= 0);
    corrupt_wa = base[31:2] + 30'(v.corrupt);
    f0 = tot_fires; r0 = tot_rsp; q0 = tot_req_cyc;
    s0 = tot_stab_bad; o0 = tot_ovf; b0 = tot_fire_bad;

    chk({tag, " cmd_ready"}, 32'(cmd_ready_o), 32'd1);
    cmd_valid_i   = 1'b1;
    cmd_op_i      = v.op;
    cmd_addr_i    = v.addr;
    cmd_len_i     = LW'(v.len);
    cmd_pattern_i = v.pat;
    t0 = cyc;
    @(negedge clk_i); #1;
    cmd_valid_i   = 1'b0;
    cmd_op_i      = ~v.op;
    cmd_addr_i    = $urandom;
    cmd_len_i     = LW'($urandom);
    cmd_pattern_i = $urandom;

    dcyc = -1;
    for (int i = 0; i < 3000 && dcyc < 0; i++) begin
      if (done_o) dcyc = cyc;
      else begin
        @(negedge clk_i); #1;
      end
    end
    chk({tag, " done_seen"}, 32'(dcyc >= 0), 32'd1);
    if (v.exp_lat >= 0) chk({tag, " done_latency"}, 32'(dcyc - t0), 32'(v.exp_lat));
    chk({tag, " busy_in_done"}, 32'(busy_o), 32'd0);
    chk({tag, " err_cnt"}, 32'(err_cnt_o), 32'(v.exp_err));
    chk({tag, " err_addr"}, err_addr_o, v.exp_eaddr);
    chk({tag, " grants"}, 32'(tot_fires - f0), 32'(v.len));
    chk({tag, " responses"}, 32'(tot_rsp - r0), 32'(v.len));
    chk({tag, " word_addr_data_errs"}, 32'(tot_fire_bad - b0), 32'd0);
    chk({tag, " unstable_while_ungranted"}, 32'(tot_stab_bad - s0), 32'd0);
    chk({tag, " over_max_outstanding"}, 32'(tot_ovf - o0), 32'd0);
    if (!v.stall) begin
      chk({tag, " req_cycles"}, 32'(tot_req_cyc - q0), 32'(v.len));
      if (v.len > 0) begin
        chk({tag, " req_first_cycle"}, 32'(rise_cyc - t0), 32'd1);
        chk({tag, " req_last_cycle"}, 32'(last_req_cyc - t0), 32'(v.len));
      end
    end
    if (v.op) begin
      bad = 0;
      for (int k = 0; k < v.len; k++) begin
        wa = base[31:2] + 30'(k);
        if (!mem.exists(wa) || mem[wa] !== v.pat + 32'(k)) bad++;
      end
      chk({tag, " mem_image_bad_words"}, 32'(bad), 32'd0);
    end
    @(negedge clk_i); #1;
    chk({tag, " done_one_cycle"}, 32'(done_o), 32'd0);
    chk({tag, " ready_after_done"}, 32'(cmd_ready_o), 32'd1);
    corrupt_en = 1'b0;
  endtask

  vec_t vecs[9];

  initial begin
    //           op    addr           len pattern        stall corrupt err     err_addr       lat
    vecs[0] = '{1'b1, 32'h1C00_0000, 4,  32'h0000_00A0, 1'b0, -1, 16'd0,  32'h0000_0000, 6};
    vecs[1] = '{1'b0, 32'h1C00_0000, 4,  32'h0000_00A0, 1'b0, -1, 16'd0,  32'h0000_0000, 6};
    vecs[2] = '{1'b0, 32'h1C00_0000, 4,  32'h0000_00A0, 1'b0,  2, 16'd1,  32'h1C00_0008, 6};
    vecs[3] = '{1'b0, 32'h1C00_0003, 4,  32'h0000_00A0, 1'b0, -1, 16'd0,  32'h0000_0000, 6};
    vecs[4] = '{1'b1, 32'hFFFF_FFF8, 4,  32'h1234_5678, 1'b0, -1, 16'd0,  32'h0000_0000, 6};
    vecs[5] = '{1'b1, 32'h2000_0000, 64, 32'hFFFF_FFF0, 1'b1, -1, 16'd0,  32'h0000_0000, -1};
    vecs[6] = '{1'b0, 32'h2000_0000, 64, 32'hFFFF_FFF0, 1'b1, -1, 16'd0,  32'h0000_0000, -1};
    vecs[7] = '{1'b0, 32'h2000_0000, 64, 32'hFFFF_FFF1, 1'b1, -1, 16'd64, 32'h2000_0000, -1};
    vecs[8] = '{1'b1, 32'h0000_1000, 0,  32'h0000_0000, 1'b0, -1, 16'd0,  32'h0000_0000, 1};

    repeat (3) @(negedge clk_i);
    #1;
    chk("reset req", 32'(bus.req), 32'd0);
    chk("reset add", bus.add, 32'h0);
    chk("reset wen_be", 32'({bus.wen, bus.be}), 32'h1F);
    chk("reset wdata", bus.wdata, 32'h0);
    chk("reset busy_done", 32'({busy_o, done_o}), 32'd0);
    chk("reset err_cnt", 32'(err_cnt_o), 32'd0);
    chk("reset err_addr", err_addr_o, 32'h0);
    rst_ni = 1'b1;
    @(negedge clk_i); #1;

    for (int i = 0; i < 9; i++) run_vec($sformatf("v%0d", i), vecs[i]);

    // Reset while one write is outstanding and the next is waiting for grant.
    slv_en        = 1'b0;
    man_gnt       = 1'b1;
    man_rvalid    = 1'b0;
    cmd_valid_i   = 1'b1;
    cmd_op_i      = 1'b1;
    cmd_addr_i    = 32'h3000_0000;
    cmd_len_i     = LW'(4);
    cmd_pattern_i = 32'h5;
    @(negedge clk_i); #1;
    cmd_valid_i = 1'b0;
    chk("rstseq word0 req", 32'(bus.req), 32'd1);
    @(negedge clk_i); #1;
    man_gnt = 1'b0;
    chk("rstseq busy", 32'(busy_o), 32'd1);
    chk("rstseq word1 add", bus.add, 32'h3000_0004);
    rst_ni = 1'b0;
    #1;
    chk("rstseq req_dropped", 32'(bus.req), 32'd0);
    chk("rstseq add", bus.add, 32'h0);
    chk("rstseq wen_wdata", 32'(bus.wen) ^ bus.wdata, 32'd1);
    chk("rstseq busy_done", 32'({busy_o, done_o}), 32'd0);
    @(negedge clk_i); #1;
    rst_ni = 1'b1;
    @(negedge clk_i); #1;
    man_rvalid = 1'b1;
    @(negedge clk_i); #1;
    man_rvalid = 1'b0;
    @(negedge clk_i); #1;
    chk("rstseq stray_idle", 32'({cmd_ready_o, busy_o, done_o, bus.req}), 32'h8);
    chk("rstseq stray_err", 32'(err_cnt_o), 32'd0);

    run_vec("post_rst", vecs[1]);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
